// File: rtl/fir_pkg.sv
// Shared types, default widths and width/saturation helpers for the folded FIR filters.
package fir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAC   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_ROUND = 3'd3,
    ST_OUT   = 3'd4
  } fir_state_e;

  localparam int DEF_NUM_TAPS  = 102;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_COEF_W    = 32;
  localparam int DEF_OUT_W     = 32;
  localparam int DEF_FRAC_BITS = 31;

  // Saturation limits are built at this width and sliced down by the user.
  localparam int SAT_LIM_W = 128;

  function automatic int fir_acc_width(input int data_w, input int coef_w, input int num_taps);
    return data_w + coef_w + $clog2(num_taps);
  endfunction

  function automatic logic signed [SAT_LIM_W-1:0] fir_sat_hi(input int out_w);
    logic signed [SAT_LIM_W-1:0] one;
    one = SAT_LIM_W'(1);
    return (one <<< (out_w - 1)) - one;
  endfunction

  function automatic logic signed [SAT_LIM_W-1:0] fir_sat_lo(input int out_w);
    logic signed [SAT_LIM_W-1:0] one;
    one = SAT_LIM_W'(1);
    return -(one <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up, arithmetic right shift by FRAC_BITS, then clamp to a signed OUT_W result.
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int ACC_W     = 66,
  parameter int OUT_W     = 32,
  parameter int FRAC_BITS = 31
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] data_o,
  output logic                    sat_o
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam int RW = ACC_W + 1;
  localparam logic signed [SAT_LIM_W-1:0] HI_FULL = fir_sat_hi(OUT_W);
  localparam logic signed [SAT_LIM_W-1:0] LO_FULL = fir_sat_lo(OUT_W);
  localparam logic signed [RW-1:0] SAT_HI = HI_FULL[RW-1:0];
  localparam logic signed [RW-1:0] SAT_LO = LO_FULL[RW-1:0];

  logic signed [RW-1:0] acc_ext;
  logic signed [RW-1:0] rounded;
  logic signed [RW-1:0] shifted;

  assign acc_ext = {acc_i[ACC_W-1], acc_i};

  generate
    if (FRAC_BITS > 0) begin : g_round
      localparam logic signed [RW-1:0] HALF = RW'(1) << (FRAC_BITS - 1);
      assign rounded = acc_ext + HALF;
    end else begin : g_no_round
      assign rounded = acc_ext;
    end
  endgenerate

  assign shifted = rounded >>> FRAC_BITS;

  always_comb begin
    data_o = shifted[OUT_W-1:0];
    sat_o  = 1'b0;
    if (shifted > SAT_HI) begin
      data_o = SAT_HI[OUT_W-1:0];
      sat_o  = 1'b1;
    end else if (shifted < SAT_LO) begin
      data_o = SAT_LO[OUT_W-1:0];
      sat_o  = 1'b1;
    end
  end

endmodule

// File: rtl/fir_stream_folded.sv
// Folded N-tap FIR: one multiplier walks all taps per sample, valid/ready on both sides.
//   state | meaning
//   IDLE  | waiting for a sample; coefficient writes accepted
//   MAC   | one product per cycle, tap 0 .. NUM_TAPS-1
//   DRAIN | last product folded into the accumulator
//   ROUND | round/saturate accumulator into the output register
//   OUT   | result presented until m_ready
module fir_stream_folded
  import fir_pkg::*;
#(
  parameter int NUM_TAPS  = DEF_NUM_TAPS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic signed [DATA_W-1:0]    s_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic signed [OUT_W-1:0]     m_data,
  output logic                        m_sat,
  input  logic                        coef_we,
  input  logic [$clog2(NUM_TAPS)-1:0] coef_addr,
  input  logic signed [COEF_W-1:0]    coef_wdata,
  output logic                        busy
);

  localparam int ACC_W  = fir_acc_width(DATA_W, COEF_W, NUM_TAPS);
  localparam int ADDR_W = $clog2(NUM_TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TAPS - 1);
  localparam logic [ADDR_W:0]   TAPS_LIM = (ADDR_W + 1)'(NUM_TAPS);

  fir_state_e state_q, state_d;

  logic signed [DATA_W-1:0] hist_q [NUM_TAPS];
  logic signed [COEF_W-1:0] coef_q [NUM_TAPS];
  logic [ADDR_W-1:0]        wr_ptr_q;
  logic [ADDR_W-1:0]        rd_ptr_q;
  logic [ADDR_W-1:0]        tap_q;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [OUT_W-1:0]  m_data_q;
  logic                     m_sat_q;

  logic signed [PROD_W-1:0] coef_ext;
  logic signed [PROD_W-1:0] hist_ext;
  logic signed [PROD_W-1:0] prod_d;
  logic signed [ACC_W-1:0]  prod_acc;
  logic signed [OUT_W-1:0]  rs_data;
  logic                     rs_sat;
  logic                     accept;
  logic                     coef_ok;
  logic                     last_tap;

  // Ready is forced low during reset and during a flush cycle.
  assign s_ready  = rst_n & ~clear & (state_q == ST_IDLE);
  assign accept   = s_valid & s_ready;
  assign coef_ok  = coef_we & (state_q == ST_IDLE) & ({1'b0, coef_addr} < TAPS_LIM);
  assign last_tap = (tap_q == LAST_IDX);

  assign m_valid = (state_q == ST_OUT);
  assign busy    = (state_q != ST_IDLE);
  assign m_data  = m_data_q;
  assign m_sat   = m_sat_q;

  assign coef_ext = {{DATA_W{coef_q[tap_q][COEF_W-1]}}, coef_q[tap_q]};
  assign hist_ext = {{COEF_W{hist_q[rd_ptr_q][DATA_W-1]}}, hist_q[rd_ptr_q]};
  assign prod_d   = coef_ext * hist_ext;
  assign prod_acc = {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (accept) state_d = ST_MAC;
        ST_MAC:   if (last_tap) state_d = ST_DRAIN;
        ST_DRAIN: state_d = ST_ROUND;
        ST_ROUND: state_d = ST_OUT;
        ST_OUT:   if (m_ready) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) hist_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tap_q    <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      m_data_q <= '0;
      m_sat_q  <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < NUM_TAPS; i++) hist_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tap_q    <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      m_data_q <= '0;
      m_sat_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            hist_q[wr_ptr_q] <= s_data;
            rd_ptr_q         <= wr_ptr_q;
            tap_q            <= '0;
            prod_q           <= '0;
            acc_q            <= '0;
          end
        end
        ST_MAC: begin
          // Product of the previous tap is accumulated while the next one is formed.
          prod_q   <= prod_d;
          acc_q    <= acc_q + prod_acc;
          tap_q    <= last_tap ? '0 : tap_q + 1'b1;
          rd_ptr_q <= (rd_ptr_q == '0) ? LAST_IDX : rd_ptr_q - 1'b1;
        end
        ST_DRAIN: begin
          acc_q <= acc_q + prod_acc;
        end
        ST_ROUND: begin
          m_data_q <= rs_data;
          m_sat_q  <= rs_sat;
        end
        ST_OUT: begin
          if (m_ready) wr_ptr_q <= (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Coefficients survive a flush; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) coef_q[i] <= '0;
    end else if (coef_ok) begin
      coef_q[coef_addr] <= coef_wdata;
    end
  end

  fir_round_sat #(
    .ACC_W     (ACC_W),
    .OUT_W     (OUT_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_round_sat (
    .acc_i  (acc_q),
    .data_o (rs_data),
    .sat_o  (rs_sat)
  );

endmodule
